// File: rtl/cpu_mem_pkg.sv
// cpu_mem_pkg: state/channel encodings, latency counter width and LFSR constants for cpu_mem_responder
package cpu_mem_pkg;
    localparam int CNT_W = 4;
    localparam logic [3:0] S_IDLE  = 4'b0001;
    localparam logic [3:0] S_GNT   = 4'b0010;
    localparam logic [3:0] S_RWAIT = 4'b0100;
    localparam logic [3:0] S_RESP  = 4'b1000;
    localparam logic CH_INST = 1'b0;
    localparam logic CH_DATA = 1'b1;
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    // Taps 16,14,13,11 map to bits 15,13,12,10
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {s[14:0], ^(s & LFSR_TAPS)};
    endfunction

    // Saturate so a jittered latency never wraps the 4-bit counter
    function automatic logic [CNT_W-1:0] lat_load(input int base, input logic [1:0] extra);
        int sum;
        sum = base + int'(extra);
        return (sum > 2**CNT_W - 1) ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
    endfunction
endpackage

// File: rtl/mem_ram_bank.sv
// mem_ram_bank: single-port 2^ADDR_WIDTH x 32 RAM with byte strobes and synchronous read
module mem_ram_bank #(
  parameter int    ADDR_WIDTH = 12,
  parameter string INIT_FILE  = ""
) (
  input  logic                  clk,
  input  logic                  en,
  input  logic                  wr,
  input  logic [3:0]            strb,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [31:0]           wdata,
  output logic [31:0]           rdata
);
  logic [31:0] mem [2**ADDR_WIDTH];
  always_ff @(posedge clk)
    if (en) begin
      if (wr) begin
        for (int i = 0; i < 4; i++)
          if (strb[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end else begin
        rdata <= mem[addr];
      end
    end
endmodule

// File: rtl/cpu_mem_responder.sv
// cpu_mem_responder: latency-programmable memory responder for the CPU instruction/data valid-ready channels.
// Define MEM_RAND_LAT_EN to add 0-3 cycles of LFSR jitter to both latencies.
module cpu_mem_responder
    import cpu_mem_pkg::*;
#(
    parameter int    ADDR_WIDTH = 12,
    parameter int    REQ_LAT    = 1,
    parameter int    RSP_LAT    = 2,
    parameter string INIT_FILE  = ""
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] PC,
    input  logic        Inst_Req_Valid,
    output logic        Inst_Req_Ready,
    output logic [31:0] Instruction,
    output logic        Inst_Valid,
    input  logic        Inst_Ready,
    input  logic [31:0] Address,
    input  logic        MemWrite,
    input  logic [31:0] Write_data,
    input  logic [3:0]  Write_strb,
    input  logic        MemRead,
    output logic        Mem_Req_Ready,
    output logic [31:0] Read_data,
    output logic        Read_data_Valid,
    input  logic        Read_data_Ready
);
    logic [3:0]       state;
    logic [CNT_W-1:0] cnt;
    logic             ch;
    logic [31:0]      inst_q, rd_q, ram_q, byte_addr;
    logic [1:0]       extra;
    logic             req_data, ch_req, accept, is_store, rsp_ready, unused_addr;

    assign req_data        = MemRead | MemWrite;
    assign ch_req          = (ch == CH_DATA) ? req_data : Inst_Req_Valid;
    assign accept          = (state == S_GNT) && (cnt == '0) && ch_req;
    assign is_store        = (ch == CH_DATA) && MemWrite;
    assign rsp_ready       = (ch == CH_DATA) ? Read_data_Ready : Inst_Ready;
    assign Inst_Req_Ready  = accept && (ch == CH_INST);
    assign Mem_Req_Ready   = accept && (ch == CH_DATA);
    assign Inst_Valid      = (state == S_RESP) && (ch == CH_INST);
    assign Read_data_Valid = (state == S_RESP) && (ch == CH_DATA);
    assign Instruction     = inst_q;
    assign Read_data       = rd_q;
    assign byte_addr       = (ch == CH_DATA) ? Address : PC;
    // Upper address bits are deliberately ignored so accesses alias
    assign unused_addr     = ^{byte_addr[31:ADDR_WIDTH+2], byte_addr[1:0]};

`ifdef MEM_RAND_LAT_EN
    logic [15:0] lfsr;
    always_ff @(posedge clk or negedge rst)
        if (!rst) lfsr <= LFSR_SEED;
        else lfsr <= lfsr_next(lfsr);
    assign extra = lfsr[1:0];
`else
    assign extra = 2'b00;
`endif

    mem_ram_bank #(.ADDR_WIDTH(ADDR_WIDTH), .INIT_FILE(INIT_FILE)) u_ram (
        .clk  (clk),
        .en   (accept),
        .wr   (is_store),
        .strb (Write_strb),
        .addr (byte_addr[ADDR_WIDTH+1:2]),
        .wdata(Write_data),
        .rdata(ram_q)
    );

    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            state  <= S_IDLE;
            cnt    <= '0;
            ch     <= CH_INST;
            inst_q <= '0;
            rd_q   <= '0;
        end else begin
            case (state)
                S_IDLE:
                    if (req_data || Inst_Req_Valid) begin
                        ch    <= req_data ? CH_DATA : CH_INST;
                        cnt   <= lat_load(REQ_LAT, extra);
                        state <= S_GNT;
                    end
                S_GNT:
                    if (cnt != '0) cnt <= cnt - 1'b1;
                    else if (!ch_req || is_store) state <= S_IDLE;
                    else begin
                        cnt   <= lat_load(RSP_LAT - 1, extra);
                        state <= S_RWAIT;
                    end
                S_RWAIT:
                    if (cnt != '0) cnt <= cnt - 1'b1;
                    else begin
                        state <= S_RESP;
                        if (ch == CH_DATA) rd_q <= ram_q;
                        else inst_q <= ram_q;
                    end
                S_RESP:
                    if (rsp_ready) state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
endmodule

// File: tb/tb_cpu_mem_responder.sv
// tb_cpu_mem_responder: directed vector table, corner-case sequences and randomized traffic against a word-array memory model
module tb_cpu_mem_responder;
    localparam int REQ_LAT = 1;
    localparam int RSP_LAT = 2;
`ifdef MEM_RAND_LAT_EN
    localparam int SLACK = 3;
`else
    localparam int SLACK = 0;
`endif

    logic        clk, rst;
    logic [31:0] PC, Instruction, Address, Write_data, Read_data;
    logic        Inst_Req_Valid, Inst_Req_Ready, Inst_Valid, Inst_Ready;
    logic        MemWrite, MemRead, Mem_Req_Ready, Read_data_Valid, Read_data_Ready;
    logic [3:0]  Write_strb;

    int n_cmp = 0;
    int n_bad = 0;

    cpu_mem_responder #(.ADDR_WIDTH(12), .REQ_LAT(REQ_LAT), .RSP_LAT(RSP_LAT), .INIT_FILE("")) dut (
        .clk(clk), .rst(rst),
        .PC(PC), .Inst_Req_Valid(Inst_Req_Valid), .Inst_Req_Ready(Inst_Req_Ready),
        .Instruction(Instruction), .Inst_Valid(Inst_Valid), .Inst_Ready(Inst_Ready),
        .Address(Address), .MemWrite(MemWrite), .Write_data(Write_data), .Write_strb(Write_strb),
        .MemRead(MemRead), .Mem_Req_Ready(Mem_Req_Ready),
        .Read_data(Read_data), .Read_data_Valid(Read_data_Valid), .Read_data_Ready(Read_data_Ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_rng(input string name, input int act, input int lo, input int hi);
        n_cmp++;
        if (act < lo || act > hi) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    // kind: 0 fetch, 1 load, 2 store. Latencies are counted in cycles after the sampling edge.
    task automatic xact(input int kind, input logic [31:0] a, input logic [31:0] wd, input logic [3:0] sb,
                        input int hold, input logic [31:0] exp);
        int n;
        bit seen;
        @(posedge clk); #1;
        PC = a; Address = a; Write_data = wd; Write_strb = sb;
        Inst_Req_Valid = (kind == 0); MemRead = (kind == 1); MemWrite = (kind == 2);
        n = 0; seen = 0;
        while (!seen && n < 40) begin
            @(negedge clk);
            seen = (kind == 0) ? Inst_Req_Ready : Mem_Req_Ready;
            if (!seen) n++;
        end
        chk_rng("req_lat", n, REQ_LAT + 1, REQ_LAT + 1 + SLACK);
        @(posedge clk); #1;
        Inst_Req_Valid = 0; MemRead = 0; MemWrite = 0;
        if (!seen) return;
        if (kind == 2) begin
            @(negedge clk);
            chk("store_no_rsp", {30'd0, Inst_Valid, Read_data_Valid}, 0);
            return;
        end
        n = 1; seen = 0;
        while (!seen && n < 40) begin
            @(negedge clk);
            seen = (kind == 0) ? Inst_Valid : Read_data_Valid;
            if (!seen) n++;
        end
        chk_rng("rsp_lat", n, RSP_LAT + 1, RSP_LAT + 1 + SLACK);
        if (!seen) return;
        chk("rsp_data", (kind == 0) ? Instruction : Read_data, exp);
        repeat (hold) begin
            @(negedge clk);
            chk("hold_valid", {31'd0, (kind == 0) ? Inst_Valid : Read_data_Valid}, 1);
            chk("hold_data", (kind == 0) ? Instruction : Read_data, exp);
        end
        @(posedge clk); #1;
        Inst_Ready = (kind == 0); Read_data_Ready = (kind == 1);
        @(negedge clk);
        chk("hs_valid", {31'd0, (kind == 0) ? Inst_Valid : Read_data_Valid}, 1);
        @(posedge clk); #1;
        Inst_Ready = 0; Read_data_Ready = 0;
        @(negedge clk);
        chk("post_valid", {31'd0, (kind == 0) ? Inst_Valid : Read_data_Valid}, 0);
        chk("post_data_hold", (kind == 0) ? Instruction : Read_data, exp);
    endtask

    typedef struct {
        int          kind;
        logic [31:0] a;
        logic [31:0] wd;
        logic [3:0]  sb;
        int          hold;
        logic [31:0] exp;
    } vec_t;

    vec_t tv[13];
    logic [31:0] model[32];

    initial begin
        int mr, dv, ir, iv, nrv, early, n;
        rst = 0; PC = 0; Address = 0; Write_data = 0; Write_strb = 0;
        Inst_Req_Valid = 0; MemRead = 0; MemWrite = 0; Inst_Ready = 0; Read_data_Ready = 0;
        repeat (2) @(negedge clk);
        chk("reset_ctrl", {28'd0, Inst_Req_Ready, Inst_Valid, Mem_Req_Ready, Read_data_Valid}, 0);
        chk("reset_inst", Instruction, 0);
        chk("reset_rdata", Read_data, 0);
        rst = 1;

        tv[0]  = '{2, 32'h0000_0040, 32'h2408_0005, 4'hF,    0, 32'h0};
        tv[1]  = '{0, 32'h0000_0040, 32'h0,         4'h0,    0, 32'h2408_0005};
        tv[2]  = '{2, 32'h0000_000C, 32'h1122_3344, 4'hF,    0, 32'h0};
        tv[3]  = '{2, 32'h0000_000C, 32'h00AB_0000, 4'b0100, 0, 32'h0};
        tv[4]  = '{1, 32'h0000_000C, 32'h0,         4'h0,    4, 32'h11AB_3344};
        tv[5]  = '{2, 32'h0000_4000, 32'hDEAD_BEEF, 4'hF,    0, 32'h0};
        tv[6]  = '{1, 32'h0000_0000, 32'h0,         4'h0,    1, 32'hDEAD_BEEF};
        tv[7]  = '{2, 32'h0000_000C, 32'hFFFF_FFFF, 4'h0,    0, 32'h0};
        tv[8]  = '{0, 32'h0000_000C, 32'h0,         4'h0,    2, 32'h11AB_3344};
        tv[9]  = '{2, 32'h0000_0000, 32'h5566_7788, 4'b1001, 0, 32'h0};
        tv[10] = '{1, 32'h1000_0000, 32'h0,         4'h0,    0, 32'h55AD_BE88};
        tv[11] = '{2, 32'h0000_FFFC, 32'h0A0B_0C0D, 4'hF,    0, 32'h0};
        tv[12] = '{0, 32'h0000_3FFC, 32'h0,         4'h0,    0, 32'h0A0B_0C0D};
        for (int i = 0; i < 13; i++) xact(tv[i].kind, tv[i].a, tv[i].wd, tv[i].sb, tv[i].hold, tv[i].exp);

        // Load and fetch together: data first, fetch only after the load handshake
        mr = -1; dv = -1; ir = -1; iv = -1; nrv = 0; early = 0;
        @(posedge clk); #1;
        Address = 32'h0C; MemRead = 1; PC = 32'h40; Inst_Req_Valid = 1;
        Read_data_Ready = 1; Inst_Ready = 1;
        for (int c = 0; c < 80 && iv < 0; c++) begin
            @(negedge clk);
            if (Inst_Req_Ready && dv < 0) early++;
            if (Mem_Req_Ready) mr = c;
            if (Read_data_Valid) begin
                nrv++;
                if (dv < 0) begin dv = c; chk("sim_load_data", Read_data, 32'h11AB_3344); end
            end
            if (Inst_Req_Ready && dv >= 0) ir = c;
            if (Inst_Valid) begin iv = c; chk("sim_inst_data", Instruction, 32'h2408_0005); end
            @(posedge clk); #1;
            if (mr >= 0) MemRead = 0;
            if (ir >= 0) Inst_Req_Valid = 0;
        end
        MemRead = 0; Inst_Req_Valid = 0; Read_data_Ready = 0; Inst_Ready = 0;
        chk("sim_inst_early", early, 0);
        chk_rng("sim_mem_rdy", mr, REQ_LAT + 1, REQ_LAT + 1 + SLACK);
        chk_rng("sim_load_valid", dv - mr, RSP_LAT + 1, RSP_LAT + 1 + SLACK);
        chk_rng("sim_inst_rdy", ir - dv, REQ_LAT + 2, REQ_LAT + 2 + SLACK);
        chk_rng("sim_inst_valid", iv - ir, RSP_LAT + 1, RSP_LAT + 1 + SLACK);
        chk("sim_rd_valid_cycles", nrv, 1);

        // Fetch request withdrawn before its grant
        @(posedge clk); #1;
        PC = 32'h40; Inst_Req_Valid = 1;
        @(posedge clk); #1;
        Inst_Req_Valid = 0;
        n = 0;
        repeat (10) begin @(negedge clk); if (Inst_Req_Ready || Inst_Valid) n++; end
        chk("drop_no_activity", n, 0);

        // Reset before a store is accepted: RAM keeps the old word
        @(posedge clk); #1;
        Address = 32'h0C; MemWrite = 1; Write_data = 32'h0; Write_strb = 4'hF;
        @(negedge clk);
        @(negedge clk);
        chk("rst_store_no_rdy", {31'd0, Mem_Req_Ready}, 0);
        rst = 0; #1;
        MemWrite = 0;
        @(negedge clk);
        rst = 1;
        xact(1, 32'h0C, 0, 0, 0, 32'h11AB_3344);

        // Reset during the response wait: outputs drop at once, no Valid afterwards
        @(posedge clk); #1;
        Address = 32'h0C; MemRead = 1;
        n = 0;
        while (!Mem_Req_Ready && n < 40) begin @(negedge clk); if (!Mem_Req_Ready) n++; end
        chk_rng("rst_rwait_rdy", n, REQ_LAT + 1, REQ_LAT + 1 + SLACK);
        @(posedge clk); #1;
        MemRead = 0;
        @(negedge clk);
        rst = 0; #1;
        chk("rst_rwait_ctrl", {28'd0, Inst_Req_Ready, Inst_Valid, Mem_Req_Ready, Read_data_Valid}, 0);
        chk("rst_rwait_rdata", Read_data, 0);
        chk("rst_rwait_inst", Instruction, 0);
        @(negedge clk);
        rst = 1;
        n = 0;
        repeat (10) begin @(negedge clk); if (Read_data_Valid) n++; end
        chk("rst_rwait_no_valid", n, 0);

        // Randomized traffic over 32 words reached through aliased addresses
        for (int i = 0; i < 32; i++) begin
            logic [31:0] a, wd;
            a = ($urandom() & 32'hFFFF_C000) | (i << 2);
            wd = $urandom();
            xact(2, a, wd, 4'hF, 0, 0);
            model[i] = wd;
        end
        for (int k = 0; k < 1000; k++) begin
            int idx, kind;
            logic [31:0] a, wd;
            logic [3:0] sb;
            idx = int'($urandom_range(0, 31));
            kind = int'($urandom_range(0, 2));
            a = ($urandom() & 32'hFFFF_C000) | (idx << 2);
            if (kind == 2) begin
                wd = $urandom();
                sb = 4'($urandom_range(0, 15));
                xact(2, a, wd, sb, 0, 0);
                for (int b = 0; b < 4; b++) if (sb[b]) model[idx][8*b +: 8] = wd[8*b +: 8];
            end else begin
                xact(kind, a, 0, 0, int'($urandom_range(0, 3)), model[idx]);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
